// File: rtl/ram_march_pkg.sv
// Shared encodings for the RAM March C- self-test: element table, phase and FSM state.
package ram_march_pkg;

  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_e;
  typedef enum logic       {PH_RD, PH_WR}           phase_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN}   state_e;

  typedef struct packed {
    logic down;    // element walks NUM_BYTES-1 -> 0
    logic rd_one;  // read expects ~PATTERN
    logic wr_one;  // write stores ~PATTERN
    logic has_rd;
    logic has_wr;
  } elem_cfg_t;

  function automatic elem_cfg_t elem_cfg(input elem_e e);
    case (e)
      M0:      elem_cfg = elem_cfg_t'(5'b00001);
      M1:      elem_cfg = elem_cfg_t'(5'b00111);
      M2:      elem_cfg = elem_cfg_t'(5'b01011);
      M3:      elem_cfg = elem_cfg_t'(5'b10111);
      M4:      elem_cfg = elem_cfg_t'(5'b11011);
      M5:      elem_cfg = elem_cfg_t'(5'b00010);
      default: elem_cfg = elem_cfg_t'(5'b00000);
    endcase
  endfunction

  function automatic logic elem_down(input elem_e e);
    elem_down = (e == M3) || (e == M4);
  endfunction

  function automatic elem_e next_elem(input elem_e e);
    case (e)
      M0:      next_elem = M1;
      M1:      next_elem = M2;
      M2:      next_elem = M3;
      M3:      next_elem = M4;
      M4:      next_elem = M5;
      default: next_elem = M5;
    endcase
  endfunction

endpackage

// File: rtl/ram_march_addr_gen.sv
// Up/down RAM address counter with element-start load and end-of-element flag.
module ram_march_addr_gen
  import ram_march_pkg::*;
#(
  parameter int ADDR_BITS = 6,
  parameter int NUM_BYTES = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_load_down,
  input  logic                 i_step,
  input  logic                 i_down,
  output logic [ADDR_BITS-1:0] o_addr,
  output logic                 o_last
);

  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(NUM_BYTES - 1);

  logic [ADDR_BITS-1:0] r_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_addr <= '0;
    else if (i_load) r_addr <= i_load_down ? LAST : '0;
    else if (i_step) r_addr <= i_down ? r_addr - 1'b1 : r_addr + 1'b1;
  end

  assign o_addr = r_addr;
  // End is detected at the far address, so the counter never wraps inside an element.
  assign o_last = i_down ? (r_addr == '0) : (r_addr == LAST);

endmodule

// File: rtl/ram_march_tester.sv
// March C- BIST initiator for a single-port byte RAM; stops on first mismatch.
module ram_march_tester
  import ram_march_pkg::*;
#(
  parameter int          ADDR_BITS = 6,
  parameter int          NUM_BYTES = 48,
  parameter logic [7:0]  PATTERN   = 8'h55
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ADDR_BITS-1:0] fail_addr,
  output logic [7:0]           fail_exp,
  output logic [7:0]           fail_got,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_we,
  input  logic [7:0]           mem_rdata
);

  state_e               r_state;
  elem_e                r_elem;
  phase_e               r_phase;
  logic                 r_we;
  logic [7:0]           r_wdata;
  logic                 r_pass;
  logic [ADDR_BITS-1:0] r_faddr;
  logic [7:0]           r_fexp;
  logic [7:0]           r_fgot;

  elem_cfg_t            w_cfg;
  logic [7:0]           w_exp;
  logic [7:0]           w_wval;
  logic                 w_rd_cycle;
  logic                 w_mismatch;
  logic                 w_addr_done;
  logic                 w_step;
  logic                 w_load;
  logic                 w_load_down;
  logic                 w_last;
  logic [ADDR_BITS-1:0] w_addr;

  always_comb begin
    w_cfg       = elem_cfg(r_elem);
    w_exp       = w_cfg.rd_one ? ~PATTERN : PATTERN;
    w_wval      = w_cfg.wr_one ? ~PATTERN : PATTERN;
    w_rd_cycle  = (r_state == S_RUN) && (r_phase == PH_RD);
    w_mismatch  = w_rd_cycle && (mem_rdata != w_exp);
    // Current address is finished: its last op this element completed without error.
    w_addr_done = (r_state == S_RUN) && !w_mismatch && !(w_rd_cycle && w_cfg.has_wr);
    w_step      = w_addr_done && !w_last;
    w_load      = ((r_state == S_IDLE) && start) ||
                  (w_addr_done && w_last && (r_elem != M5));
    w_load_down = (r_state == S_RUN) && elem_down(next_elem(r_elem));
  end

  ram_march_addr_gen #(
    .ADDR_BITS (ADDR_BITS),
    .NUM_BYTES (NUM_BYTES)
  ) u_addr (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_load_down (w_load_down),
    .i_step      (w_step),
    .i_down      (w_cfg.down),
    .o_addr      (w_addr),
    .o_last      (w_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_elem  <= M0;
      r_phase <= PH_RD;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_pass  <= 1'b0;
      r_faddr <= '0;
      r_fexp  <= '0;
      r_fgot  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_RUN;
          r_elem  <= M0;
          r_phase <= PH_WR;
          r_we    <= 1'b1;
          r_wdata <= PATTERN;
          r_pass  <= 1'b0;
          r_faddr <= '0;
          r_fexp  <= '0;
          r_fgot  <= '0;
        end
        S_RUN: begin
          if (w_mismatch) begin
            r_state <= S_FIN;
            r_we    <= 1'b0;
            r_pass  <= 1'b0;
            r_faddr <= w_addr;
            r_fexp  <= w_exp;
            r_fgot  <= mem_rdata;
          end else if (w_rd_cycle && w_cfg.has_wr) begin
            r_phase <= PH_WR;
            r_we    <= 1'b1;
            r_wdata <= w_wval;
          end else if (!w_last) begin
            r_phase <= w_cfg.has_rd ? PH_RD : PH_WR;
            r_we    <= !w_cfg.has_rd;
          end else if (r_elem == M5) begin
            r_state <= S_FIN;
            r_we    <= 1'b0;
            r_pass  <= 1'b1;
          end else begin
            // Every element after M0 opens with a read.
            r_elem  <= next_elem(r_elem);
            r_phase <= PH_RD;
            r_we    <= 1'b0;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_FIN);
  assign pass      = r_pass;
  assign fail_addr = r_faddr;
  assign fail_exp  = r_fexp;
  assign fail_got  = r_fgot;
  assign mem_addr  = w_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = r_we;

endmodule

// File: tb/tb_ram_march_tester.sv
// Bench for ram_march_tester: faulty-RAM model plus a plain-loop March C- reference.
module tb_ram_march_tester;
  localparam int         AB  = 6;
  localparam int         NB  = 48;
  localparam logic [7:0] PAT = 8'h55;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic          busy, done, pass, mem_we;
  logic [AB-1:0] fail_addr, mem_addr;
  logic [7:0]    fail_exp, fail_got, mem_wdata, mem_rdata;

  ram_march_tester #(.ADDR_BITS(AB), .NUM_BYTES(NB), .PATTERN(PAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  // fault configuration, shared by the RAM model and the reference
  bit         st_en = 0, st_val = 0; int st_addr = 0, st_bit = 0;
  bit         al_en = 0;             int al_from = 0, al_to = 0;
  bit         cp_en = 0;             int cp_aggr = 0, cp_vic = 0;
  logic [7:0] cp_val = 8'h00;

  logic [7:0] ram [64];
  logic [7:0] ref_mem [64];

  typedef struct { int a; bit we; logic [7:0] d; } op_t;
  op_t           q[$];
  bit            x_pass;
  logic [AB-1:0] x_addr;
  logic [7:0]    x_exp, x_got;

  function automatic int phys(input int a);
    return (al_en && a == al_from) ? al_to : a;
  endfunction

  function automatic logic [7:0] rd_fix(input int p, input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (st_en && p == st_addr) r[st_bit] = st_val;
    return r;
  endfunction

  always_comb begin
    int p;
    p = (al_en && int'(mem_addr) == al_from) ? al_to : int'(mem_addr);
    mem_rdata = ram[p];
    if (st_en && p == st_addr) mem_rdata[st_bit] = st_val;
  end

  always @(posedge clk) begin
    if (mem_we) begin
      ram[phys(int'(mem_addr))] <= mem_wdata;
      if (cp_en && phys(int'(mem_addr)) == cp_aggr && mem_wdata == cp_val) ram[cp_vic] <= cp_val;
    end
  end

  // Walks the March C- table directly and records every expected RAM op.
  task automatic ref_run();
    bit         dn [6] = '{0, 0, 0, 1, 1, 0};
    bit         hr [6] = '{0, 1, 1, 1, 1, 1};
    bit         hw [6] = '{1, 1, 1, 1, 1, 0};
    logic [7:0] rv [6] = '{8'h00, PAT, ~PAT, PAT, ~PAT, PAT};
    logic [7:0] wv [6] = '{PAT, ~PAT, PAT, ~PAT, PAT, 8'h00};
    q.delete();
    x_pass = 1'b1; x_addr = '0; x_exp = '0; x_got = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < NB; k++) begin
        int a, p;
        logic [7:0] g;
        a = dn[e] ? NB - 1 - k : k;
        p = phys(a);
        if (hr[e]) begin
          q.push_back('{a, 1'b0, 8'h00});
          g = rd_fix(p, ref_mem[p]);
          if (g !== rv[e]) begin
            x_pass = 1'b0; x_addr = AB'(a); x_exp = rv[e]; x_got = g;
            return;
          end
        end
        if (hw[e]) begin
          q.push_back('{a, 1'b1, wv[e]});
          ref_mem[p] = wv[e];
          if (cp_en && p == cp_aggr && wv[e] == cp_val) ref_mem[cp_vic] = cp_val;
        end
      end
    end
  endtask

  task automatic clear_faults();
    st_en = 0; al_en = 0; cp_en = 0;
  endtask

  task automatic run_chk(input string nm, input bit extra, output int cyc);
    bit bad;
    bad = 0;
    cyc = 0;
    ref_run();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (busy && cyc < 600) begin
      if (cyc >= q.size()) begin
        if (!bad) $display("FAIL %s opseq: busy cycle %0d beyond required %0d", nm, cyc + 1, q.size());
        bad = 1;
      end else if (int'(mem_addr) != q[cyc].a || mem_we !== q[cyc].we ||
                   (q[cyc].we && mem_wdata !== q[cyc].d)) begin
        if (!bad) $display("FAIL %s opseq: cycle %0d got addr=%0d we=%b wd=%h, want addr=%0d we=%b wd=%h",
                           nm, cyc + 1, mem_addr, mem_we, mem_wdata, q[cyc].a, q[cyc].we, q[cyc].d);
        bad = 1;
      end
      cyc++;
      if (extra && cyc == 7) start = 1'b1;
      if (extra && cyc == 8) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    n_vec++; if (bad) n_err++;
    n_vec++;
    if (cyc != q.size()) begin
      n_err++; $display("FAIL %s busy_cycles: got %0d want %0d", nm, cyc, q.size());
    end
    n_vec++;
    if ({busy, done, pass} !== {1'b0, 1'b1, x_pass}) begin
      n_err++; $display("FAIL %s done_pass: got busy/done/pass=%b%b%b want 01%b", nm, busy, done, pass, x_pass);
    end
    n_vec++;
    if ({fail_addr, fail_exp, fail_got} !== {x_addr, x_exp, x_got}) begin
      n_err++; $display("FAIL %s fail_fields: got %0d/%h/%h want %0d/%h/%h",
                        nm, fail_addr, fail_exp, fail_got, x_addr, x_exp, x_got);
    end
    if (extra) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n_vec++;
    if ({busy, done, pass} !== {1'b0, 1'b0, x_pass}) begin
      n_err++; $display("FAIL %s after_fin: got busy/done/pass=%b%b%b want 00%b", nm, busy, done, pass, x_pass);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, done, pass, fail_addr, fail_exp, fail_got, mem_addr, mem_wdata, mem_we} !== '0) begin
      n_err++; $display("FAIL reset_state: got busy=%b done=%b pass=%b we=%b addr=%0d", busy, done, pass, mem_we, mem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fault_free();
    int c;
    clear_faults();
    run_chk("fault_free", 1'b0, c);
    n_vec++;
    if (c != 10 * NB || pass !== 1'b1) begin
      n_err++; $display("FAIL fault_free_len: got %0d cycles pass=%b want %0d pass=1", c, pass, 10 * NB);
    end
  endtask

  task automatic test_stuck_at();
    int c;
    clear_faults(); st_en = 1; st_addr = 5; st_bit = 0; st_val = 1'b0;
    run_chk("stuck5", 1'b0, c);
    n_vec++;
    if (c != 59 || pass !== 1'b0 || fail_addr !== 6'd5 || fail_exp !== 8'h55 || fail_got !== 8'h54) begin
      n_err++; $display("FAIL stuck5_spec: got cyc=%0d pass=%b %0d/%h/%h want 59 0 5/55/54", c, pass, fail_addr, fail_exp, fail_got);
    end
  endtask

  task automatic test_alias();
    int c;
    clear_faults(); al_en = 1; al_from = 40; al_to = 8;
    run_chk("alias40", 1'b0, c);
    n_vec++;
    if (c <= NB || c > 3 * NB || fail_addr !== 6'd40 || fail_exp !== 8'h55 || fail_got !== 8'hAA) begin
      n_err++; $display("FAIL alias40_spec: got cyc=%0d %0d/%h/%h want M1 40/55/aa", c, fail_addr, fail_exp, fail_got);
    end
  endtask

  task automatic test_coupling();
    int c;
    clear_faults(); cp_en = 1; cp_aggr = 20; cp_vic = 19; cp_val = 8'hAA;
    run_chk("cpl20_19", 1'b0, c);
    n_vec++;
    if (c != 297 || fail_addr !== 6'd19 || fail_exp !== 8'h55 || fail_got !== 8'hAA) begin
      n_err++; $display("FAIL cpl_spec: got cyc=%0d %0d/%h/%h want 297 19/55/aa", c, fail_addr, fail_exp, fail_got);
    end
  endtask

  task automatic test_ignored_start();
    int c;
    clear_faults();
    run_chk("extra_start_pass", 1'b1, c);
    n_vec++;
    if (c != 10 * NB) begin
      n_err++; $display("FAIL extra_start_len: got %0d want %0d", c, 10 * NB);
    end
    st_en = 1; st_addr = 5; st_bit = 0; st_val = 1'b0;
    run_chk("extra_start_fail", 1'b1, c);
  endtask

  task automatic test_random();
    int c, a, b;
    for (int it = 0; it < 8; it++) begin
      clear_faults();
      a = $urandom_range(0, NB - 1);
      b = (a + $urandom_range(1, NB - 1)) % NB;
      case ($urandom_range(0, 3))
        0: begin st_en = 1; st_addr = a; st_bit = $urandom_range(0, 7); st_val = 1'($urandom_range(0, 1)); end
        1: begin al_en = 1; al_from = a; al_to = b; end
        2: begin cp_en = 1; cp_aggr = a; cp_vic = b; cp_val = $urandom_range(0, 1) ? 8'hAA : 8'h55; end
        default: ;
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_chk("random", 1'b0, c);
    end
  endtask

  task automatic test_async_reset();
    int c, k;
    clear_faults();
    c = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (busy && c < 99) begin c++; @(negedge clk); end
    n_vec++;
    if (c != 99 || busy !== 1'b1) begin
      n_err++; $display("FAIL arst_reach: got %0d busy cycles busy=%b want 99 busy=1", c, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, done, pass, fail_addr, fail_exp, fail_got, mem_addr, mem_wdata, mem_we} !== '0) begin
      n_err++; $display("FAIL arst_immediate: got busy=%b done=%b we=%b addr=%0d wd=%h", busy, done, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    run_chk("after_arst", 1'b0, k);
    n_vec++;
    if (k != 10 * NB || pass !== 1'b1) begin
      n_err++; $display("FAIL after_arst_len: got %0d pass=%b want %0d pass=1", k, pass, 10 * NB);
    end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_stuck_at();
    test_alias();
    test_coupling();
    test_ignored_start();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
